// File: rtl/exu_mdu_seq.sv
// Iterative RV32M multiply/divide sequencer: radix-2 shift-add multiply and restoring
// divide, one bit per clock, with valid/ready handshakes on both sides.
module exu_mdu_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] rs1_value,
    input  logic [XLEN-1:0] rs2_value,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0]   CNT_LAST = CW'(XLEN - 1);
    localparam logic [CW-1:0]   CNT_ONE  = CW'(1);
    localparam logic [XLEN-1:0] MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]        state_reg;
    logic [2:0]        op_reg;
    logic [CW-1:0]     cnt_reg;
    logic              neg_reg;
    logic [XLEN-1:0]   opb_reg;
    logic [2*XLEN-1:0] prod_reg;
    logic [XLEN-1:0]   rem_reg;
    logic [XLEN-1:0]   result_reg;

    // Operand decode for the offered op
    logic            a_signed, b_signed, sign_a, sign_b;
    logic [XLEN-1:0] a_abs, b_abs;
    logic            div_zero, div_ovf, special;
    logic [XLEN-1:0] special_result;
    logic            neg_in;

    always_comb begin
        a_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        b_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        sign_a   = a_signed & rs1_value[XLEN-1];
        sign_b   = b_signed & rs2_value[XLEN-1];
        a_abs    = sign_a ? -rs1_value : rs1_value;
        b_abs    = sign_b ? -rs2_value : rs2_value;
        div_zero = op[2] && (rs2_value == '0);
        div_ovf  = op[2] && !op[0] && (rs1_value == MIN_NEG) && (rs2_value == '1);
        special  = div_zero || div_ovf;
        if (div_zero)
            special_result = op[1] ? rs1_value : '1;
        else
            special_result = op[1] ? '0 : MIN_NEG;
        // Remainder follows the dividend's sign; quotient and product use the xor
        neg_in = (op == 3'd6) ? sign_a : (sign_a ^ sign_b);
    end

    // One iteration of the datapath and the final sign fix-up
    logic [XLEN:0]     mul_sum;
    logic [XLEN:0]     div_shift;
    logic [XLEN:0]     div_diff;
    logic              div_ge;
    logic [2*XLEN-1:0] fix_mul;
    logic [XLEN-1:0]   div_val;
    logic [XLEN-1:0]   fix_result;

    always_comb begin
        mul_sum   = {1'b0, prod_reg[2*XLEN-1:XLEN]} + {1'b0, opb_reg};
        div_shift = {rem_reg, prod_reg[XLEN-1]};
        div_diff  = div_shift - {1'b0, opb_reg};
        // Partial remainder is always below twice the divisor, so the top bit is the sign
        div_ge    = ~div_diff[XLEN];
        fix_mul   = neg_reg ? -prod_reg : prod_reg;
        div_val   = op_reg[1] ? rem_reg : prod_reg[XLEN-1:0];
        if (op_reg[2])
            fix_result = neg_reg ? -div_val : div_val;
        else if (op_reg == 3'd0)
            fix_result = fix_mul[XLEN-1:0];
        else
            fix_result = fix_mul[2*XLEN-1:XLEN];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= S_IDLE;
            op_reg     <= '0;
            cnt_reg    <= '0;
            neg_reg    <= 1'b0;
            opb_reg    <= '0;
            prod_reg   <= '0;
            rem_reg    <= '0;
            result_reg <= '0;
        end else if (flush) begin
            state_reg <= S_IDLE;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (in_valid) begin
                        op_reg  <= op;
                        neg_reg <= neg_in;
                        cnt_reg <= '0;
                        rem_reg <= '0;
                        // Multiply: multiplier in the low half, multiplicand aside.
                        // Divide: dividend shifts out of the low half as quotient shifts in.
                        prod_reg <= {{XLEN{1'b0}}, (op[2] ? a_abs : b_abs)};
                        opb_reg  <= op[2] ? b_abs : a_abs;
                        if (special) begin
                            result_reg <= special_result;
                            state_reg  <= S_DONE;
                        end else begin
                            state_reg <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    if (op_reg[2]) begin
                        rem_reg  <= div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
                        prod_reg <= {{XLEN{1'b0}}, prod_reg[XLEN-2:0], div_ge};
                    end else if (prod_reg[0]) begin
                        prod_reg <= {mul_sum, prod_reg[XLEN-1:1]};
                    end else begin
                        prod_reg <= {1'b0, prod_reg[2*XLEN-1:1]};
                    end
                    cnt_reg <= cnt_reg + CNT_ONE;
                    if (cnt_reg == CNT_LAST)
                        state_reg <= S_FIX;
                end
                S_FIX: begin
                    result_reg <= fix_result;
                    state_reg  <= S_DONE;
                end
                S_DONE: begin
                    if (out_ready)
                        state_reg <= S_IDLE;
                end
                default: state_reg <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == S_IDLE);
    assign out_valid = (state_reg == S_DONE);
    assign busy      = (state_reg != S_IDLE);
    assign result    = result_reg;

endmodule
